ccc_decoder_4x4: RTL and testbench
==================================

Name: ccc_decoder_4x4

Overview:
Downstream counterpart of the CCC 4x4 encoder. It consumes one 64-bit CCC block: a 16-bit bitmap plus two RGB888 bucket colours. It expands the block back into a 4x4 tile of RGB888 pixels and presents the tile as a 384-bit word, with a start/done handshake. It sits on the playback path between the CCC block fetch logic and the frame/tile writer.

Parameters:
ROWS_PER_CYCLE, 1, tile rows expanded per clock; legal values 1, 2, 4; any other value is a static elaboration error.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-low reset
ccc_data  input  64  CCC block; sampled only on the accepting edge
start  input  1  request a decode; honoured only when idle
rgb_data  output  384  decoded tile, registered; pixel i = y*4+x at [i*24 +: 24]; R at +16, G at +8, B at +0
busy  output  1  registered; high from the accepting edge until the final-row edge
done  output  1  registered; one-cycle pulse, rgb_data complete

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, rgb_data=0, busy=0, done=0, row counter=0, latched block=0. This takes effect immediately, including mid-decode; a partial tile is discarded.
- CCC layout: [63:48] bitmap, bit i selects pixel i. [47:24] colour0 {R,G,B}. [23:0] colour1 {R,G,B}.
- Pixel rule: bitmap bit i=1 -> pixel i = colour1 (bright bucket); bit i=0 -> pixel i = colour0. No arithmetic; pure selection, widths unchanged.
- FSM states: IDLE, EXPAND.
- IDLE: on a rising edge with start=1, latch ccc_data into an internal register, clear the row counter, set busy=1, go to EXPAND. With start=0, stay in IDLE; rgb_data holds.
- EXPAND: each edge writes ROWS_PER_CYCLE consecutive rows (row r = pixels 4r..4r+3) from the latched block. The row counter advances by ROWS_PER_CYCLE.
- The edge that writes row 3 also sets done=1, busy=0, state=IDLE.
- Latency: start sampled at edge E0 -> done high after edge E0+4/ROWS_PER_CYCLE. Example: 4 edges for ROWS_PER_CYCLE=1, 1 edge for ROWS_PER_CYCLE=4.
- done is high exactly one cycle. rgb_data is fully valid while done=1 and holds until the next decode's first row write.
- Rows not yet rewritten during a decode keep the previous tile's values. Consumers must not read rgb_data while busy=1.
- start while busy=1 is ignored; a changing ccc_data is also ignored, because the latched copy is used.
- start held high continuously: back-to-back decodes. Each next decode is accepted on the edge after the done edge. Period is 4/ROWS_PER_CYCLE+1 cycles.
- done and start share no combinational path: done is never a function of start in the same cycle.

Decomposition:
- Package ccc_pkg, shared with the encoder:
  - BITS_PER_PIXEL=24 and BITS_PER_BLOCK=64.
  - Field offsets: CCC_BITMAP_LSB=48, CCC_C0_LSB=24, CCC_C1_LSB=0.
  - Channel offsets: R=16, G=8, B=0.
  - Decoder state enum.
- Sub-module ccc_row_expand (combinational): inputs 4 bitmap bits plus colour0/colour1; output one 96-bit row. The decoder instantiates ROWS_PER_CYCLE copies.

Test Plan:
1. ccc={16'h0000, 24'h102030, 24'hA0B0C0}, start pulse, ROWS_PER_CYCLE=1 -> done high exactly after 4th edge post-accept; all 16 pixels = 24'h102030; busy high for the 4 intervening cycles.
2. ccc={16'hA5A5, 24'h000000, 24'hFFFFFF} -> pixels 0,2,5,7,8,10,13,15 = 24'hFFFFFF, all others = 24'h000000.
3. Accept {16'hFFFF, 24'h111111, 24'h223344}; on the next cycle drive start=1 with ccc={16'h0000, 24'h555555, 24'h666666} -> second request ignored; final tile all 24'h223344; only one done pulse.
4. start held high, ccc changes from block A to block B on the done cycle -> done pulses every 5 cycles; second tile matches B.
5. rst driven low asynchronously (between clock edges) after row 1 is written -> rgb_data=0, busy=0, done=0 immediately. After release, a fresh decode of test 2's block gives the correct result.
6. ROWS_PER_CYCLE=2 and =4, block from test 2 -> done after 2 and 1 edges respectively; tile identical to test 2.

Source files
------------

// File: rtl/ccc_pkg.sv
// Shared CCC definitions: block layout, pixel/channel geometry and decoder state.
package ccc_pkg;

    localparam int unsigned BITS_PER_PIXEL = 24;
    localparam int unsigned BITS_PER_BLOCK = 64;
    localparam int unsigned CHANNEL_W      = 8;
    localparam int unsigned BITMAP_W       = 16;

    localparam int unsigned PIXELS_PER_ROW = 4;
    localparam int unsigned ROWS_PER_TILE  = 4;
    localparam int unsigned BITS_PER_ROW   = PIXELS_PER_ROW * BITS_PER_PIXEL;
    localparam int unsigned BITS_PER_TILE  = ROWS_PER_TILE * BITS_PER_ROW;

    // Field offsets inside a CCC block
    localparam int unsigned CCC_BITMAP_LSB = 48;
    localparam int unsigned CCC_C0_LSB     = 24;
    localparam int unsigned CCC_C1_LSB     = 0;

    // Channel offsets inside an RGB888 pixel
    localparam int unsigned CH_R_LSB = 16;
    localparam int unsigned CH_G_LSB = 8;
    localparam int unsigned CH_B_LSB = 0;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } dec_state_e;

endpackage

// File: rtl/ccc_row_expand.sv
// Expands one 4-pixel tile row: each bitmap bit picks colour1 (1) or colour0 (0).
// Ports:
//   bits   - 4 bitmap bits, bit j selects pixel j of the row
//   color0 - dark bucket colour {R,G,B}
//   color1 - bright bucket colour {R,G,B}
//   row_c  - 96-bit row, pixel j at [j*24 +: 24] (combinational)
module ccc_row_expand
    import ccc_pkg::*;
(
    input  logic [PIXELS_PER_ROW-1:0] bits,
    input  logic [BITS_PER_PIXEL-1:0] color0,
    input  logic [BITS_PER_PIXEL-1:0] color1,
    output logic [BITS_PER_ROW-1:0]   row_c
);

    logic [BITS_PER_PIXEL-1:0] sel;

    // Pure selection, copied channel by channel
    always_comb begin
        row_c = '0;
        sel   = '0;
        for (int j = 0; j < int'(PIXELS_PER_ROW); j++) begin
            sel = bits[j] ? color1 : color0;
            row_c[j*BITS_PER_PIXEL + CH_R_LSB +: CHANNEL_W] = sel[CH_R_LSB +: CHANNEL_W];
            row_c[j*BITS_PER_PIXEL + CH_G_LSB +: CHANNEL_W] = sel[CH_G_LSB +: CHANNEL_W];
            row_c[j*BITS_PER_PIXEL + CH_B_LSB +: CHANNEL_W] = sel[CH_B_LSB +: CHANNEL_W];
        end
    end

endmodule

// File: rtl/ccc_decoder_4x4.sv
// CCC 4x4 block decoder: expands a 64-bit CCC block into a 4x4 RGB888 tile,
// ROWS_PER_CYCLE rows per clock, with start/busy/done handshake.
// Ports:
//   clk      - rising-edge clock
//   rst      - asynchronous active-low reset
//   ccc_data - CCC block, sampled on the accepting edge only
//   start    - decode request, honoured only when idle
//   rgb_data - registered tile, pixel i = y*4+x at [i*24 +: 24]
//   busy     - registered, high while rows are being expanded
//   done     - registered one-cycle pulse, tile complete
module ccc_decoder_4x4
    import ccc_pkg::*;
#(
    parameter int unsigned ROWS_PER_CYCLE = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [BITS_PER_BLOCK-1:0] ccc_data,
    input  logic                      start,
    output logic [BITS_PER_TILE-1:0]  rgb_data,
    output logic                      busy,
    output logic                      done
);

    // One extra bit so the counter can reach ROWS_PER_TILE without wrapping
    localparam int unsigned CNT_W = 3;
    localparam int unsigned IDX_W = 2;

    if (!(ROWS_PER_CYCLE == 1 || ROWS_PER_CYCLE == 2 || ROWS_PER_CYCLE == 4)) begin : g_bad_rpc
        $error("ccc_decoder_4x4: ROWS_PER_CYCLE must be 1, 2 or 4");
    end

    dec_state_e                state_q, state_d;
    logic [CNT_W-1:0]          row_q, row_d;
    logic [BITS_PER_BLOCK-1:0] blk_q, blk_d;
    logic [BITS_PER_TILE-1:0]  rgb_q, rgb_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic [BITMAP_W-1:0]       bitmap;
    logic [BITS_PER_PIXEL-1:0] color0;
    logic [BITS_PER_PIXEL-1:0] color1;
    logic                      last_rows;

    logic [IDX_W-1:0]          row_idx [ROWS_PER_CYCLE];
    logic [BITS_PER_ROW-1:0]   row_px  [ROWS_PER_CYCLE];

    assign bitmap = blk_q[CCC_BITMAP_LSB +: BITMAP_W];
    assign color0 = blk_q[CCC_C0_LSB +: BITS_PER_PIXEL];
    assign color1 = blk_q[CCC_C1_LSB +: BITS_PER_PIXEL];

    // Row expanders work from the latched block, never from ccc_data directly
    for (genvar k = 0; k < int'(ROWS_PER_CYCLE); k++) begin : g_row
        assign row_idx[k] = row_q[IDX_W-1:0] + IDX_W'(k);

        ccc_row_expand u_row_expand (
            .bits   (bitmap[{row_idx[k], 2'b00} +: PIXELS_PER_ROW]),
            .color0 (color0),
            .color1 (color1),
            .row_c  (row_px[k])
        );
    end

    assign last_rows = (row_q + CNT_W'(ROWS_PER_CYCLE)) == CNT_W'(ROWS_PER_TILE);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            blk_q   <= '0;
            rgb_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            blk_q   <= blk_d;
            rgb_q   <= rgb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        blk_d   = blk_q;
        rgb_d   = rgb_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    blk_d   = ccc_data;
                    row_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_EXPAND;
                end
            end

            ST_EXPAND: begin
                // Only the rows addressed this cycle change; the rest keep the old tile
                for (int r = 0; r < int'(ROWS_PER_TILE); r++) begin
                    for (int k = 0; k < int'(ROWS_PER_CYCLE); k++) begin
                        if (row_idx[k] == IDX_W'(r)) begin
                            rgb_d[r*BITS_PER_ROW +: BITS_PER_ROW] = row_px[k];
                        end
                    end
                end
                row_d = row_q + CNT_W'(ROWS_PER_CYCLE);
                if (last_rows) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rgb_data = rgb_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_ccc_decoder_4x4.sv
// Scoreboard bench for ccc_decoder_4x4 at ROWS_PER_CYCLE = 1, 2 and 4.
module tb_ccc_decoder_4x4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [63:0]  ccc = '0;
    logic         start1 = 1'b0;
    logic         start2 = 1'b0;
    logic         start4 = 1'b0;
    logic [383:0] rgb1, rgb2, rgb4;
    logic         busy1, busy2, busy4;
    logic         done1, done2, done4;

    int checks   = 0;
    int failures = 0;
    int dones1   = 0;

    logic [383:0] q1[$];
    logic [383:0] q2[$];
    logic [383:0] q4[$];

    localparam logic [63:0] BLK_T1  = {16'h0000, 24'h102030, 24'hA0B0C0};
    localparam logic [63:0] BLK_T2  = {16'hA5A5, 24'h000000, 24'hFFFFFF};
    localparam logic [63:0] BLK_T3A = {16'hFFFF, 24'h111111, 24'h223344};
    localparam logic [63:0] BLK_T3B = {16'h0000, 24'h555555, 24'h666666};
    localparam logic [63:0] BLK_T4A = {16'h1234, 24'h0A0B0C, 24'hD0E0F0};
    localparam logic [63:0] BLK_T4B = {16'hC3C3, 24'h010203, 24'h404142};
    localparam logic [63:0] BLK_T5  = {16'h00FF, 24'hABCDEF, 24'h123456};

    always #5 clk = ~clk;

    ccc_decoder_4x4 #(.ROWS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .ccc_data(ccc), .start(start1),
        .rgb_data(rgb1), .busy(busy1), .done(done1)
    );
    ccc_decoder_4x4 #(.ROWS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst(rst), .ccc_data(ccc), .start(start2),
        .rgb_data(rgb2), .busy(busy2), .done(done2)
    );
    ccc_decoder_4x4 #(.ROWS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .ccc_data(ccc), .start(start4),
        .rgb_data(rgb4), .busy(busy4), .done(done4)
    );

    task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference tile: bit i set -> colour1, else colour0
    function automatic logic [383:0] model_tile(input logic [63:0] blk);
        logic [383:0] t;
        logic [15:0]  bm;
        bm = blk[63:48];
        t  = '0;
        for (int i = 0; i < 16; i++)
            t[i*24 +: 24] = bm[i] ? blk[23:0] : blk[47:24];
        return t;
    endfunction

    function automatic logic [1:0] busy_done(input int which);
        case (which)
            2:       return {busy2, done2};
            4:       return {busy4, done4};
            default: return {busy1, done1};
        endcase
    endfunction

    // Scoreboard monitors: every done pops one expected tile
    always @(negedge clk) begin
        if (done1) begin
            dones1++;
            if (q1.size() == 0) check("d1_spurious_done", 384'(1), 384'(0));
            else                check("d1_tile", rgb1, q1.pop_front());
        end
        if (done2) begin
            if (q2.size() == 0) check("d2_spurious_done", 384'(1), 384'(0));
            else                check("d2_tile", rgb2, q2.pop_front());
        end
        if (done4) begin
            if (q4.size() == 0) check("d4_spurious_done", 384'(1), 384'(0));
            else                check("d4_tile", rgb4, q4.pop_front());
        end
    end

    // Single-pulse decode; entered and left just after a rising edge
    task automatic run_dec(input int which, input logic [63:0] blk, input int lat, input string tag);
        ccc = blk;
        case (which)
            2:       begin start2 = 1'b1; q2.push_back(model_tile(blk)); end
            4:       begin start4 = 1'b1; q4.push_back(model_tile(blk)); end
            default: begin start1 = 1'b1; q1.push_back(model_tile(blk)); end
        endcase
        @(posedge clk); #1;
        start1 = 1'b0; start2 = 1'b0; start4 = 1'b0;
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            if (k < lat) check($sformatf("%s_busy_c%0d", tag, k), 384'(busy_done(which)), 384'(2'b10));
            else         check($sformatf("%s_done_c%0d", tag, k), 384'(busy_done(which)), 384'(2'b01));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int base;
        int first;
        int second;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_rgb1", rgb1, 384'(0));
        check("rst_bd1", 384'({busy1, done1}), 384'(0));
        check("rst_rgb4", rgb4, 384'(0));
        rst = 1'b1;
        @(posedge clk); #1;

        // Uniform tile and checkerboard-like bitmap
        run_dec(1, BLK_T1, 4, "t1");
        run_dec(1, BLK_T2, 4, "t2");

        // Request while busy is ignored
        base   = dones1;
        ccc    = BLK_T3A;
        start1 = 1'b1;
        q1.push_back(model_tile(BLK_T3A));
        @(posedge clk); #1;
        ccc = BLK_T3B;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("t3_done_count", 384'(dones1 - base), 384'(1));
        check("t3_tile", rgb1, {16{24'h223344}});

        // Back-to-back with start held high; block changes on the done cycle
        first  = -1;
        second = -1;
        ccc    = BLK_T4A;
        start1 = 1'b1;
        q1.push_back(model_tile(BLK_T4A));
        q1.push_back(model_tile(BLK_T4B));
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (done1) begin
                if (first < 0) begin
                    first = cyc;
                    ccc   = BLK_T4B;
                end else if (second < 0) begin
                    second = cyc;
                    start1 = 1'b0;
                end
            end
        end
        start1 = 1'b0;
        check("t4_period", 384'(second - first), 384'(5));
        @(posedge clk); #1;

        // Asynchronous reset mid-decode, after row 1 is written
        ccc    = BLK_T5;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("t5_rst_rgb", rgb1, 384'(0));
        check("t5_rst_bd", 384'({busy1, done1}), 384'(0));
        check("t5_rst_rgb2", rgb2, 384'(0));
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        run_dec(1, BLK_T2, 4, "t5_after");

        // Wider expansion: 2 and 4 rows per cycle
        run_dec(2, BLK_T2, 2, "t6_rpc2");
        run_dec(4, BLK_T2, 1, "t6_rpc4");

        repeat (3) @(posedge clk);
        #1;
        check("sb_drain", 384'(q1.size() + q2.size() + q4.size()), 384'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
